interrupt_acceptor: RTL and testbench
=====================================

INTERRUPT_ACCEPTOR -- requirements
Module: interrupt_acceptor

Interface
REQ-001 Parameter POLL_GAP, default 4, meaning idle cycles between controller polls (legal range 1..255).
REQ-002 Parameter VEC_HI, default 8'hFF, meaning the high byte of every vector address.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 ctrl_vector  input  8  vector low byte from the interrupt controller; 8'h00 means nothing pending.
REQ-006 ctrl_read  output  1  read strobe to the interrupt controller.
REQ-007 dev_pri  input  24  device priorities; bits [3k+2:3k] are the priority of device k (k=0..7).
REQ-008 cpu_pri  input  3  current CPU priority, PSW[7:5].
REQ-009 ie  input  1  global interrupt enable.
REQ-010 irq  output  1  interrupt request to the CPU control unit.
REQ-011 cpu_ack  input  1  CPU accepts the request (one-cycle pulse).
REQ-012 vec_addr  output  16  vector address of the held interrupt, {VEC_HI, low byte}.
REQ-013 vec_pri  output  3  priority of the held interrupt.
REQ-014 vec_err  output  1  sticky flag: an unrecognised vector byte was captured.

Function
REQ-015 The FSM SHALL have states IDLE, POLL, CAPTURE, HELD and REQ.
REQ-016 IDLE: a gap counter increments each cycle; when it reaches POLL_GAP-1, the FSM clears the counter and enters POLL.
REQ-017 POLL: ctrl_read=1 for exactly one cycle, then CAPTURE. ctrl_read is 0 in every other state.
REQ-018 CAPTURE: ctrl_vector is sampled.
- 8'h00 -> IDLE.
- Recognised byte -> HELD.
- Any other byte -> vec_err set, FSM returns to IDLE.
REQ-019 Recognised bytes and device indices: C2=0, C6=1, CA=2, CE=3, D2=4, D6=5, EE=6, F2=7.
REQ-020 On entry to HELD, vec_addr={VEC_HI, byte} and vec_pri=dev_pri field of the decoded device. Both are registered and hold stable until the next capture.
REQ-021 The accept condition is ie=1 AND vec_pri > cpu_pri (unsigned, 3-bit compare).
REQ-022 HELD: when the accept condition is true, the FSM enters REQ. Otherwise it stays in HELD and issues no polls. A captured vector is never discarded except by cpu_ack or reset.
REQ-023 REQ: irq=1, registered, asserted the cycle after entering REQ. irq is 0 in every other state.
REQ-024 REQ with cpu_ack=1 -> IDLE; irq falls the next cycle; the gap counter restarts from 0.
REQ-025 REQ with the accept condition false and cpu_ack=0 -> HELD; irq deasserts.
REQ-026 cpu_ack and a falling accept condition in the same cycle: cpu_ack wins.
REQ-027 cpu_ack outside REQ is ignored.
REQ-028 vec_pri=7 is accepted whenever ie=1 and cpu_pri<7. vec_pri=0 is never accepted.

Reset
REQ-029 When rst_n=0, the block SHALL immediately force:
- State=IDLE, gap counter=0.
- ctrl_read=0, irq=0, vec_addr=16'h0000, vec_pri=0, vec_err=0.
REQ-030 Reset in any state, including mid-POLL or REQ, drops the held vector. The first poll occurs POLL_GAP cycles after rst_n rises.
REQ-031 vec_err clears only on reset.

Verification
REQ-032 Poll cadence: POLL_GAP=4, ctrl_vector=00 constant -> ctrl_read pulses once every 6 cycles; irq stays 0.
REQ-033 Basic accept: ctrl_vector=D2, dev_pri[14:12]=5, cpu_pri=2, ie=1 -> vec_addr=FFD2, vec_pri=5, irq=1; cpu_ack -> irq=0, next poll after 4 idle cycles.
REQ-034 Blocked then released: vector CE, pri 3, cpu_pri=3 -> HELD, no irq, no further ctrl_read; cpu_pri drops to 1 -> irq=1, vec_addr=FFCE.
REQ-035 Withdrawal and race:
- In REQ, ie falls -> irq=0, vector kept; ie rises -> irq=1.
- cpu_ack in the same cycle ie falls -> IDLE.
REQ-036 Bad vector: ctrl_vector=C4 at capture -> vec_err=1, irq=0, polling continues, vec_err stays 1 until rst_n=0.
REQ-037 Async reset in REQ -> all outputs 0 without a clock edge; vector F2 is lost and not re-requested until re-polled.

Source files
------------

// File: rtl/interrupt_acceptor_if.sv
// Signal bundle between the interrupt acceptor, the interrupt controller and the CPU.
// The slave modport is the acceptor's view; master is the surrounding system's view.
interface interrupt_acceptor_if;
  logic [7:0]  ctrl_vector;
  logic        ctrl_read;
  logic [23:0] dev_pri;
  logic [2:0]  cpu_pri;
  logic        ie;
  logic        irq;
  logic        cpu_ack;
  logic [15:0] vec_addr;
  logic [2:0]  vec_pri;
  logic        vec_err;

  modport slave (
    input  ctrl_vector, dev_pri, cpu_pri, ie, cpu_ack,
    output ctrl_read, irq, vec_addr, vec_pri, vec_err
  );

  modport master (
    output ctrl_vector, dev_pri, cpu_pri, ie, cpu_ack,
    input  ctrl_read, irq, vec_addr, vec_pri, vec_err
  );
endinterface

// File: rtl/interrupt_acceptor.sv
// Polls an interrupt controller for a vector byte, holds the decoded vector and
// raises irq to the CPU while the vector's priority beats the CPU priority.
module interrupt_acceptor #(
  parameter int unsigned POLL_GAP = 4,
  parameter logic [7:0]  VEC_HI   = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  interrupt_acceptor_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    POLL    = 3'd1,
    CAPTURE = 3'd2,
    HELD    = 3'd3,
    REQ     = 3'd4
  } state_t;

  localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

  state_t      state_q, state_d;
  logic [7:0]  gap_q, gap_d;
  logic [15:0] vec_addr_q, vec_addr_d;
  logic [2:0]  vec_pri_q, vec_pri_d;
  logic        vec_err_q, vec_err_d;
  logic        ctrl_read_q, ctrl_read_d;
  logic        irq_q, irq_d;

  logic [2:0]  pri_field [8];
  logic        dev_known;
  logic [2:0]  dev_idx;
  logic        accept;

  for (genvar gi = 0; gi < 8; gi++) begin : g_pri
    assign pri_field[gi] = bus.dev_pri[3*gi +: 3];
  end

  always_comb begin
    dev_known = 1'b1;
    dev_idx   = 3'd0;
    case (bus.ctrl_vector)
      8'hC2:   dev_idx = 3'd0;
      8'hC6:   dev_idx = 3'd1;
      8'hCA:   dev_idx = 3'd2;
      8'hCE:   dev_idx = 3'd3;
      8'hD2:   dev_idx = 3'd4;
      8'hD6:   dev_idx = 3'd5;
      8'hEE:   dev_idx = 3'd6;
      8'hF2:   dev_idx = 3'd7;
      default: dev_known = 1'b0;
    endcase
  end

  assign accept = bus.ie && (vec_pri_q > bus.cpu_pri);

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    vec_addr_d = vec_addr_q;
    vec_pri_d  = vec_pri_q;
    vec_err_d  = vec_err_q;
    case (state_q)
      IDLE: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = 8'd0;
          state_d = POLL;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      POLL: state_d = CAPTURE;
      CAPTURE: begin
        if (bus.ctrl_vector == 8'h00) begin
          state_d = IDLE;
        end else if (dev_known) begin
          state_d    = HELD;
          vec_addr_d = {VEC_HI, bus.ctrl_vector};
          vec_pri_d  = pri_field[dev_idx];
        end else begin
          state_d   = IDLE;
          vec_err_d = 1'b1;
        end
      end
      HELD: if (accept) state_d = REQ;
      // An acknowledge takes priority over a simultaneous loss of the accept condition.
      REQ: begin
        if (bus.cpu_ack) begin
          state_d = IDLE;
          gap_d   = 8'd0;
        end else if (!accept) begin
          state_d = HELD;
        end
      end
      default: begin
        state_d = IDLE;
        gap_d   = 8'd0;
      end
    endcase
    ctrl_read_d = (state_d == POLL);
    irq_d       = (state_d == REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gap_q       <= 8'd0;
      vec_addr_q  <= 16'h0000;
      vec_pri_q   <= 3'd0;
      vec_err_q   <= 1'b0;
      ctrl_read_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      vec_addr_q  <= vec_addr_d;
      vec_pri_q   <= vec_pri_d;
      vec_err_q   <= vec_err_d;
      ctrl_read_q <= ctrl_read_d;
      irq_q       <= irq_d;
    end
  end

  assign bus.ctrl_read = ctrl_read_q;
  assign bus.irq       = irq_q;
  assign bus.vec_addr  = vec_addr_q;
  assign bus.vec_pri   = vec_pri_q;
  assign bus.vec_err   = vec_err_q;

endmodule

// File: tb/tb_interrupt_acceptor.sv
// Self-checking bench for interrupt_acceptor: a vector table, directed corner-case
// sequences and randomized traffic against a poll-timeline reference model.
module tb_interrupt_acceptor;
  localparam int         POLL_GAP = 4;
  localparam logic [7:0] VEC_HI   = 8'hFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  interrupt_acceptor_if bus ();

  interrupt_acceptor #(.POLL_GAP(POLL_GAP), .VEC_HI(VEC_HI)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: position on the poll timeline plus a held-vector record.
  logic [7:0] known_vec [8] = '{8'hC2, 8'hC6, 8'hCA, 8'hCE, 8'hD2, 8'hD6, 8'hEE, 8'hF2};
  bit          m_pending, m_req, m_err;
  int          m_t;
  logic [15:0] m_addr;
  logic [2:0]  m_pri;

  function automatic int find_dev(input logic [7:0] v);
    for (int k = 0; k < 8; k++) if (known_vec[k] == v) return k;
    return -1;
  endfunction

  task automatic model_reset();
    m_pending = 0; m_req = 0; m_err = 0; m_t = 0; m_addr = 16'h0; m_pri = 3'd0;
  endtask

  task automatic model_step();
    bit acc;
    int k;
    if (m_pending) begin
      acc = bus.ie && (m_pri > bus.cpu_pri);
      if (m_req && bus.cpu_ack) begin
        m_pending = 0; m_req = 0; m_t = 0;
      end else begin
        m_req = acc;
      end
    end else if (m_t == POLL_GAP + 1) begin
      if (bus.ctrl_vector == 8'h00) begin
        m_t = 0;
      end else begin
        k = find_dev(bus.ctrl_vector);
        if (k >= 0) begin
          m_pending = 1; m_req = 0;
          m_addr = {VEC_HI, bus.ctrl_vector};
          m_pri  = bus.dev_pri[3*k +: 3];
        end else begin
          m_err = 1; m_t = 0;
        end
      end
    end else begin
      m_t++;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0]  vec;
    logic        ack;
    logic        e_read;
    logic        e_irq;
    logic [15:0] e_addr;
    logic [2:0]  e_pri;
  } row_t;

  row_t tbl [16];

  int reads, irqs, last_read, nz_addr, r;

  initial begin
    tbl[0]  = '{8'hD2, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0};
    tbl[1]  = '{8'hD2, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0};
    tbl[2]  = '{8'hD2, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0};
    tbl[3]  = '{8'hD2, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0};
    tbl[4]  = '{8'hD2, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0};
    tbl[5]  = '{8'hD2, 1'b0, 1'b0, 1'b0, 16'hFFD2, 3'd5};
    tbl[6]  = '{8'hD2, 1'b0, 1'b0, 1'b1, 16'hFFD2, 3'd5};
    tbl[7]  = '{8'hD2, 1'b0, 1'b0, 1'b1, 16'hFFD2, 3'd5};
    tbl[8]  = '{8'hD2, 1'b1, 1'b0, 1'b0, 16'hFFD2, 3'd5};
    tbl[9]  = '{8'hD2, 1'b0, 1'b0, 1'b0, 16'hFFD2, 3'd5};
    tbl[10] = '{8'hD2, 1'b0, 1'b0, 1'b0, 16'hFFD2, 3'd5};
    tbl[11] = '{8'hD2, 1'b0, 1'b0, 1'b0, 16'hFFD2, 3'd5};
    tbl[12] = '{8'hD2, 1'b0, 1'b1, 1'b0, 16'hFFD2, 3'd5};
    tbl[13] = '{8'hD2, 1'b0, 1'b0, 1'b0, 16'hFFD2, 3'd5};
    tbl[14] = '{8'hD2, 1'b0, 1'b0, 1'b0, 16'hFFD2, 3'd5};
    tbl[15] = '{8'hD2, 1'b0, 1'b0, 1'b1, 16'hFFD2, 3'd5};

    bus.ctrl_vector = 8'h00;
    bus.dev_pri     = 24'h005000;
    bus.cpu_pri     = 3'd2;
    bus.ie          = 1'b1;
    bus.cpu_ack     = 1'b0;

    // Reset values and basic accept / acknowledge.
    do_reset();
    chk("reset_read", bus.ctrl_read, 1'b0);
    chk("reset_irq", bus.irq, 1'b0);
    chk("reset_addr", bus.vec_addr, 16'h0000);
    chk("reset_pri", bus.vec_pri, 3'd0);
    chk("reset_err", bus.vec_err, 1'b0);
    for (int i = 0; i < 16; i++) begin
      bus.ctrl_vector = tbl[i].vec;
      bus.cpu_ack     = tbl[i].ack;
      cycle();
      $display("tbl[%0d] vec=%0h ack=%0b read=%0b irq=%0b addr=%0h pri=%0d",
               i, tbl[i].vec, tbl[i].ack, bus.ctrl_read, bus.irq, bus.vec_addr, bus.vec_pri);
      chk($sformatf("tbl%0d_read", i), bus.ctrl_read, tbl[i].e_read);
      chk($sformatf("tbl%0d_irq", i), bus.irq, tbl[i].e_irq);
      chk($sformatf("tbl%0d_addr", i), bus.vec_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_pri", i), bus.vec_pri, tbl[i].e_pri);
      chk($sformatf("tbl%0d_err", i), bus.vec_err, 1'b0);
    end
    bus.cpu_ack = 1'b0;

    // Poll cadence with nothing pending.
    bus.ctrl_vector = 8'h00;
    do_reset();
    reads = 0; irqs = 0; last_read = -1;
    for (int i = 1; i <= 36; i++) begin
      cycle();
      if (bus.irq) irqs++;
      if (bus.ctrl_read) begin
        if (last_read < 0) chk("cadence_first", 32'(i), 32'd4);
        else chk("cadence_interval", 32'(i - last_read), 32'd6);
        last_read = i;
        reads++;
      end
    end
    $display("cadence reads=%0d irqs=%0d", reads, irqs);
    chk("cadence_count", 32'(reads), 32'd6);
    chk("cadence_irq", 32'(irqs), 32'd0);

    // Blocked by CPU priority, then released.
    bus.ctrl_vector = 8'hCE; bus.dev_pri = 24'h000600; bus.cpu_pri = 3'd3; bus.ie = 1'b1;
    do_reset();
    repeat (6) cycle();
    $display("blocked addr=%0h pri=%0d irq=%0b", bus.vec_addr, bus.vec_pri, bus.irq);
    chk("blocked_addr", bus.vec_addr, 16'hFFCE);
    chk("blocked_pri", bus.vec_pri, 3'd3);
    chk("blocked_irq", bus.irq, 1'b0);
    reads = 0; irqs = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (bus.ctrl_read) reads++;
      if (bus.irq) irqs++;
    end
    chk("held_no_poll", 32'(reads), 32'd0);
    chk("held_no_irq", 32'(irqs), 32'd0);
    bus.cpu_pri = 3'd1;
    cycle();
    $display("released irq=%0b addr=%0h", bus.irq, bus.vec_addr);
    chk("released_irq", bus.irq, 1'b1);
    chk("released_addr", bus.vec_addr, 16'hFFCE);

    // Withdrawal via ie, then ack racing a falling ie.
    bus.ie = 1'b0;
    cycle();
    chk("withdraw_irq", bus.irq, 1'b0);
    chk("withdraw_addr", bus.vec_addr, 16'hFFCE);
    bus.ie = 1'b1;
    cycle();
    chk("reassert_irq", bus.irq, 1'b1);
    bus.ie = 1'b0; bus.cpu_ack = 1'b1; bus.ctrl_vector = 8'h00;
    cycle();
    chk("race_irq", bus.irq, 1'b0);
    bus.ie = 1'b1; bus.cpu_ack = 1'b0;
    reads = 0; irqs = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (bus.ctrl_read) reads++;
      if (bus.irq) irqs++;
    end
    cycle();
    $display("race aftermath read=%0b irqs=%0d", bus.ctrl_read, irqs);
    chk("race_gap_reads", 32'(reads), 32'd0);
    chk("race_gap_irq", 32'(irqs), 32'd0);
    chk("race_next_poll", bus.ctrl_read, 1'b1);

    // Unrecognised vector sets the sticky error.
    bus.ctrl_vector = 8'hC4; bus.cpu_pri = 3'd2; bus.dev_pri = 24'h005000;
    do_reset();
    repeat (6) cycle();
    $display("bad vector err=%0b irq=%0b", bus.vec_err, bus.irq);
    chk("badvec_err", bus.vec_err, 1'b1);
    chk("badvec_irq", bus.irq, 1'b0);
    bus.ctrl_vector = 8'h00;
    reads = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (bus.ctrl_read) reads++;
    end
    chk("badvec_polling", 32'(reads), 32'd1);
    chk("badvec_sticky", bus.vec_err, 1'b1);
    bus.ctrl_vector = 8'hD2;
    repeat (7) cycle();
    chk("badvec_then_irq", bus.irq, 1'b1);
    chk("badvec_sticky2", bus.vec_err, 1'b1);
    do_reset();
    chk("badvec_cleared", bus.vec_err, 1'b0);

    // Asynchronous reset while requesting.
    bus.ctrl_vector = 8'hF2; bus.dev_pri = 24'hC00000; bus.cpu_pri = 3'd0; bus.ie = 1'b1;
    do_reset();
    repeat (7) cycle();
    chk("pre_async_irq", bus.irq, 1'b1);
    chk("pre_async_addr", bus.vec_addr, 16'hFFF2);
    chk("pre_async_pri", bus.vec_pri, 3'd6);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset irq=%0b addr=%0h pri=%0d err=%0b read=%0b",
             bus.irq, bus.vec_addr, bus.vec_pri, bus.vec_err, bus.ctrl_read);
    chk("async_irq", bus.irq, 1'b0);
    chk("async_addr", bus.vec_addr, 16'h0000);
    chk("async_pri", bus.vec_pri, 3'd0);
    chk("async_read", bus.ctrl_read, 1'b0);
    chk("async_err", bus.vec_err, 1'b0);
    model_reset();
    bus.ctrl_vector = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    reads = 0; irqs = 0; nz_addr = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (bus.ctrl_read) reads++;
      if (bus.irq) irqs++;
      if (bus.vec_addr != 16'h0000) nz_addr++;
    end
    chk("lost_irq", 32'(irqs), 32'd0);
    chk("lost_addr", 32'(nz_addr), 32'd0);
    chk("lost_reads", 32'(reads), 32'd2);

    // Randomized traffic against the reference model.
    bus.cpu_ack = 1'b0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      r = int'($urandom_range(0, 9));
      if (r < 4)      bus.ctrl_vector = known_vec[$urandom_range(0, 7)];
      else if (r < 7) bus.ctrl_vector = 8'h00;
      else            bus.ctrl_vector = 8'($urandom());
      bus.ie      = ($urandom_range(0, 9) < 8);
      bus.cpu_ack = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 7) == 0)  bus.cpu_pri = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) bus.dev_pri = 24'($urandom());
      cycle();
      chk("rnd_read", bus.ctrl_read, (!m_pending && m_t == POLL_GAP));
      chk("rnd_irq", bus.irq, m_req);
      chk("rnd_addr", bus.vec_addr, m_addr);
      chk("rnd_pri", bus.vec_pri, m_pri);
      chk("rnd_err", bus.vec_err, m_err);
    end
    $display("random phase done checks=%0d", n_checks);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
